// File: rtl/cricket_pkg.sv
// Shared delivery encoding, FSM states and run lookup for the innings tracker.
package cricket_pkg;

    localparam logic [2:0] RES_DOT  = 3'd0;
    localparam logic [2:0] RES_ONE  = 3'd1;
    localparam logic [2:0] RES_TWO  = 3'd2;
    localparam logic [2:0] RES_FOUR = 3'd3;
    localparam logic [2:0] RES_SIX  = 3'd4;
    localparam logic [2:0] RES_OUT  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes 6 and 7 are unused by the field logic and score as dots.
    function automatic logic [2:0] runs_of(input logic [2:0] result);
        case (result)
            RES_ONE:  runs_of = 3'd1;
            RES_TWO:  runs_of = 3'd2;
            RES_FOUR: runs_of = 3'd4;
            RES_SIX:  runs_of = 3'd6;
            default:  runs_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Packed BCD up-counter with ripple carry; holds at all nines.
module bcd_score_counter #(
    parameter int DIGITS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    output logic [4*DIGITS-1:0] bcd,
    output logic              at_max
);

    logic [4*DIGITS-1:0] bcd_nxt;
    logic                carry;

    always_comb begin
        at_max = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd9) at_max = 1'b0;
    end

    always_comb begin
        bcd_nxt = bcd;
        carry   = inc && !at_max;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_nxt[4*i +: 4] = 4'd0;
                end else begin
                    bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) bcd <= '0;
        else       bcd <= bcd_nxt;
    end

endmodule

// File: rtl/cricket_innings_tracker.sv
// Innings scorekeeper: accepts deliveries, animates the BCD score one run per clock.
// Define TARGET_CHASE_EN to add the run-chase target and win/loss flags.
module cricket_innings_tracker
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_OVERS      = 5,
    parameter int MAX_WICKETS    = 1,
    parameter int SCORE_DIGITS   = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ball_valid,
    input  logic [2:0]                ball_result,
    output logic                      ball_ready,
    output logic                      ball_dropped,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [2:0]                runs_pending,
    output logic [2:0]                last_runs,
    output logic [3:0]                ball_in_over,
    output logic [3:0]                overs_done,
    output logic [3:0]                wickets,
    output logic                      game_over
`ifdef TARGET_CHASE_EN
    ,
    input  logic [4*SCORE_DIGITS-1:0] target_bcd,
    output logic                      chase_won,
    output logic                      chase_lost
`endif
);

    state_t     state, state_nxt;
    logic       accept, counting, at_max, chase_hit, win;
    logic       end_acc, end_cnt;
    logic [2:0] runs;
    logic [3:0] bio_nxt, ovr_nxt, wkt_nxt;

    assign ball_ready = (state == IDLE);
    assign game_over  = (state == DONE);
    assign counting   = (state == COUNT);
    assign accept     = ball_valid && ball_ready;
    assign runs       = runs_of(ball_result);

    always_comb begin
        bio_nxt = ball_in_over + 4'd1;
        ovr_nxt = overs_done;
        if (bio_nxt == 4'(BALLS_PER_OVER)) begin
            bio_nxt = 4'd0;
            ovr_nxt = overs_done + 4'd1;
        end
        wkt_nxt = wickets;
        if (ball_result == RES_OUT && wickets != 4'(MAX_WICKETS))
            wkt_nxt = wickets + 4'd1;
    end

    assign end_acc = (wkt_nxt == 4'(MAX_WICKETS)) || (ovr_nxt == 4'(MAX_OVERS));
    assign end_cnt = (wickets == 4'(MAX_WICKETS)) || (overs_done == 4'(MAX_OVERS));

    // The score about to be bumped exceeds the target iff it already equals or beats it;
    // packed BCD orders like binary, so a plain compare works.
`ifdef TARGET_CHASE_EN
    assign chase_hit = (score_bcd >= target_bcd);
`else
    assign chase_hit = 1'b0;
`endif
    assign win = counting && chase_hit && !at_max;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (runs != 3'd0)  state_nxt = COUNT;
                    else if (end_acc)  state_nxt = DONE;
                end
            end
            COUNT: begin
                if (win)                        state_nxt = DONE;
                else if (runs_pending == 3'd1)  state_nxt = end_cnt ? DONE : IDLE;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ball_dropped <= 1'b0;
            runs_pending <= 3'd0;
            last_runs    <= 3'd0;
            ball_in_over <= 4'd0;
            overs_done   <= 4'd0;
            wickets      <= 4'd0;
        end else begin
            ball_dropped <= ball_valid && !ball_ready;
            if (accept) begin
                runs_pending <= runs;
                last_runs    <= runs;
                ball_in_over <= bio_nxt;
                overs_done   <= ovr_nxt;
                wickets      <= wkt_nxt;
            end else if (counting) begin
                runs_pending <= win ? 3'd0 : runs_pending - 3'd1;
            end
        end
    end

`ifdef TARGET_CHASE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            chase_won  <= 1'b0;
            chase_lost <= 1'b0;
        end else if (win) begin
            chase_won  <= 1'b1;
        end else if (state != DONE && state_nxt == DONE) begin
            chase_lost <= 1'b1;
        end
    end
`endif

    bcd_score_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .clock  (clock),
        .reset  (reset),
        .inc    (counting),
        .bcd    (score_bcd),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_cricket_innings_tracker.sv
// Directed bench for cricket_innings_tracker: scoreboard of post-ball states plus timing checks.
module tb_cricket_innings_tracker;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic bv    = 1'b0;
    logic sel   = 1'b0;
    logic [2:0] br = 3'd0;
    logic v0, v1;

    logic        rdy0, drop0, go0;
    logic [11:0] score0;
    logic [2:0]  pend0, last0;
    logic [3:0]  bio0, ov0, wk0;

    logic        rdy1, drop1, go1;
    logic [3:0]  score1;
    logic [2:0]  pend1, last1;
    logic [3:0]  bio1, ov1, wk1;

`ifdef TARGET_CHASE_EN
    logic [11:0] target0 = 12'h999;
    logic        won0, lost0, won1, lost1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign v0 = bv && !sel;
    assign v1 = bv && sel;

    cricket_innings_tracker u0 (
        .clock(clock), .reset(reset), .ball_valid(v0), .ball_result(br),
        .ball_ready(rdy0), .ball_dropped(drop0), .score_bcd(score0),
        .runs_pending(pend0), .last_runs(last0), .ball_in_over(bio0),
        .overs_done(ov0), .wickets(wk0), .game_over(go0)
`ifdef TARGET_CHASE_EN
        , .target_bcd(target0), .chase_won(won0), .chase_lost(lost0)
`endif
    );

    cricket_innings_tracker #(
        .BALLS_PER_OVER(15), .MAX_OVERS(15), .MAX_WICKETS(10), .SCORE_DIGITS(1)
    ) u1 (
        .clock(clock), .reset(reset), .ball_valid(v1), .ball_result(br),
        .ball_ready(rdy1), .ball_dropped(drop1), .score_bcd(score1),
        .runs_pending(pend1), .last_runs(last1), .ball_in_over(bio1),
        .overs_done(ov1), .wickets(wk1), .game_over(go1)
`ifdef TARGET_CHASE_EN
        , .target_bcd(4'h9), .chase_won(won1), .chase_lost(lost1)
`endif
    );

    typedef struct {
        logic [11:0] score;
        logic [2:0]  last;
        logic [3:0]  bio, ov, wk;
        logic        go;
    } exp_t;

    exp_t sb[$];
    int   m_score, m_bio, m_ov, m_wk, m_last;
    bit   m_go;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int runs_tab(input int r);
        case (r)
            1: return 1;
            2: return 2;
            3: return 4;
            4: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bv    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        m_score = 0; m_bio = 0; m_ov = 0; m_wk = 0; m_last = 0; m_go = 0;
    endtask

    // Returns at the negedge just after the acceptance edge.
    task automatic pulse(input int r);
        @(negedge clock);
        bv = 1'b1;
        br = 3'(r);
        @(negedge clock);
        bv = 1'b0;
    endtask

    task automatic snap();
        exp_t e;
        e.score = to_bcd(m_score);
        e.last  = 3'(m_last);
        e.bio   = 4'(m_bio);
        e.ov    = 4'(m_ov);
        e.wk    = 4'(m_wk);
        e.go    = m_go;
        sb.push_back(e);
    endtask

    task automatic bowl(input int r);
        pulse(r);
        m_bio++;
        if (m_bio == 6) begin
            m_bio = 0;
            m_ov++;
        end
        if (r == 5 && m_wk < 1) m_wk++;
        m_score += runs_tab(r);
        if (m_score > 999) m_score = 999;
        m_last = runs_tab(r);
        m_go   = (m_wk == 1) || (m_ov == 5);
        snap();
    endtask

    task automatic settle(input string tag);
        exp_t e;
        int   n = 0;
        while (!(rdy0 || go0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({tag, ".bound"}, 16'(n < 40), 16'd1);
        if (sb.size() == 0) begin
            chk({tag, ".queue"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".score"}, 16'(score0), 16'(e.score));
            chk({tag, ".last"},  16'(last0),  16'(e.last));
            chk({tag, ".bio"},   16'(bio0),   16'(e.bio));
            chk({tag, ".overs"}, 16'(ov0),    16'(e.ov));
            chk({tag, ".wkts"},  16'(wk0),    16'(e.wk));
            chk({tag, ".over"},  16'(go0),    16'(e.go));
        end
    endtask

    task automatic wait_rdy1(input string tag);
        int n = 0;
        while (!rdy1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({tag, ".bound"}, 16'(n < 40), 16'd1);
    endtask

    initial begin
        do_reset();
        chk("rst.score", 16'(score0), 16'h0);
        chk("rst.ready", 16'(rdy0), 16'd1);
        chk("rst.over",  16'(go0), 16'd0);
        chk("rst.drop",  16'(drop0), 16'd0);
        chk("rst.pend",  16'(pend0), 16'd0);
        chk("rst.last",  16'(last0), 16'd0);
        chk("rst.bio",   16'(bio0), 16'd0);
        chk("rst.ov",    16'(ov0), 16'd0);
        chk("rst.wk",    16'(wk0), 16'd0);

        // Six: score animates 1..6, ready low for six cycles.
        bowl(4);
        chk("six.t.score", 16'(score0), 16'h0);
        chk("six.t.pend",  16'(pend0), 16'd6);
        chk("six.t.ready", 16'(rdy0), 16'd0);
        chk("six.t.last",  16'(last0), 16'd6);
        chk("six.t.bio",   16'(bio0), 16'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("six.score", 16'(score0), 16'(to_bcd(k)));
            chk("six.ready", 16'(rdy0), 16'(k == 6));
        end
        settle("six");

        for (int i = 0; i < 5; i++) begin
            bowl(0);
            settle("over1");
        end

        // Ball offered mid-count is dropped and leaves the score untouched.
        bowl(2);
        bv = 1'b1;
        br = 3'd3;
        @(negedge clock);
        bv = 1'b0;
        chk("cnt.drop", 16'(drop0), 16'd1);
        @(negedge clock);
        chk("cnt.drop_clr", 16'(drop0), 16'd0);
        settle("two");

        for (int i = 0; i < 22; i++) begin
            bowl(0);
            settle("dots");
        end

        // 30th ball is a four: overs complete at once, game_over only when the runs are in.
        bowl(3);
        chk("last4.ov",    16'(ov0), 16'd5);
        chk("last4.bio",   16'(bio0), 16'd0);
        chk("last4.go_t1", 16'(go0), 16'd0);
        repeat (3) @(negedge clock);
        chk("last4.go_t3", 16'(go0), 16'd0);
        chk("last4.sc_t3", 16'(score0), 16'h011);
        @(negedge clock);
        chk("last4.go_t4", 16'(go0), 16'd1);
        settle("last4");
`ifdef TARGET_CHASE_EN
        chk("last4.lost", 16'(lost0), 16'd1);
        chk("last4.won",  16'(won0), 16'd0);
`endif

        pulse(4);
        chk("done.drop", 16'(drop0), 16'd1);
        snap();
        settle("frozen");

        // Reset lands mid-count.
        do_reset();
        bowl(4);
        repeat (2) @(negedge clock);
        do_reset();
        chk("midrst.score", 16'(score0), 16'h0);
        chk("midrst.ready", 16'(rdy0), 16'd1);
        chk("midrst.pend",  16'(pend0), 16'd0);
        chk("midrst.last",  16'(last0), 16'd0);

        for (int i = 0; i < 6; i++) begin
            bowl(0);
            settle("dotover");
        end
        chk("dotover.ov", 16'(ov0), 16'd1);
        bowl(0); settle("pre_out");
        bowl(0); settle("pre_out");
        bowl(5);
        chk("out.wk", 16'(wk0), 16'd1);
        chk("out.go", 16'(go0), 16'd1);
        settle("out");
        pulse(1);
        chk("out.drop", 16'(drop0), 16'd1);
        snap();
        settle("out_frozen");
        @(negedge clock);
        chk("out.drop_clr", 16'(drop0), 16'd0);

        // One-digit score saturates at 9 while pending drains.
        do_reset();
        sel = 1'b1;
        pulse(3); wait_rdy1("sat.a");
        pulse(3); wait_rdy1("sat.b");
        chk("sat.score8", 16'(score1), 16'h8);
        pulse(3);
        chk("sat.t.pend", 16'(pend1), 16'd4);
        @(negedge clock);
        chk("sat.t1.score", 16'(score1), 16'h9);
        chk("sat.t1.pend",  16'(pend1), 16'd3);
        repeat (2) @(negedge clock);
        chk("sat.t3.ready", 16'(rdy1), 16'd0);
        @(negedge clock);
        chk("sat.t4.ready", 16'(rdy1), 16'd1);
        chk("sat.t4.score", 16'(score1), 16'h9);
        chk("sat.t4.pend",  16'(pend1), 16'd0);
        sel = 1'b0;

`ifdef TARGET_CHASE_EN
        do_reset();
        target0 = 12'h010;
        bowl(3); settle("chase.a");
        bowl(3); settle("chase.b");
        pulse(4);
        repeat (2) @(negedge clock);
        chk("chase.t2.go", 16'(go0), 16'd0);
        @(negedge clock);
        chk("chase.score", 16'(score0), 16'h011);
        chk("chase.pend",  16'(pend0), 16'd0);
        chk("chase.won",   16'(won0), 16'd1);
        chk("chase.lost",  16'(lost0), 16'd0);
        chk("chase.go",    16'(go0), 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
